// File: rtl/idma_sync_256b_rd_slv.sv
// idma_sync_256b_rd_slv: AXI read responder serving AR bursts from a 1-cycle-latency SRAM.
module idma_sync_256b_rd_slv #(
  parameter int AXI_IDW = 4,
  parameter int AXI_DATA_WID = 256,
  parameter int MEM_AW = 10,
  parameter int AR_DEPTH = 4,
  parameter logic [31:0] BASE_HI = 32'd0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_arvalid,
  input  logic [AXI_IDW-1:0]      i_arid,
  input  logic [31:0]             i_araddr,
  input  logic [3:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  output logic                    o_arready,
  output logic                    o_rvalid,
  output logic [AXI_IDW-1:0]      o_rid,
  output logic [AXI_DATA_WID-1:0] o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  input  logic                    i_rready,
  output logic                    o_mem_cs,
  output logic [MEM_AW-1:0]       o_mem_addr,
  input  logic [AXI_DATA_WID-1:0] i_mem_rdata,
  output logic                    o_busy
);
  localparam int PW = $clog2(AR_DEPTH);
  localparam int EW = AXI_IDW + MEM_AW + 6;
  localparam int TW = AXI_IDW + 2;
  localparam logic IDLE = 1'b0;
  localparam logic BURST = 1'b1;
  // queue entry: {id, word addr, len, fixed, err}
  logic [EW-1:0] q_mem_q [AR_DEPTH];
  logic [EW-1:0] q_mem_d [AR_DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d;
  logic arready_q, arready_d, state_q, state_d;
  logic [AXI_IDW-1:0] cur_id_q, cur_id_d;
  logic [MEM_AW-1:0] cur_addr_q, cur_addr_d;
  logic cur_fixed_q, cur_fixed_d, cur_err_q, cur_err_d;
  logic [4:0] beat_cnt_q, beat_cnt_d;
  logic inflight_q, inflight_d;
  logic [TW-1:0] pend_tag_q, pend_tag_d;
  logic [AXI_DATA_WID-1:0] buf_data_q [2];
  logic [AXI_DATA_WID-1:0] buf_data_d [2];
  logic [TW-1:0] buf_tag_q [2];
  logic [TW-1:0] buf_tag_d [2];
  logic buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  logic [1:0] buf_cnt_q, buf_cnt_d;
  logic push, pop, empty, issue, r_pop;
  logic [EW-1:0] head, entry;
  logic [TW-1:0] r_tag;
  assign push = i_arvalid & arready_q;
  assign empty = wp_q == rp_q;
  assign pop = (state_q == IDLE) & ~empty;
  assign head = q_mem_q[rp_q[PW-1:0]];
  assign entry = {i_arid, i_araddr[MEM_AW+4:5], i_arlen, i_arburst == 2'b00,
                  (i_araddr[31:MEM_AW+5] != BASE_HI[31-MEM_AW-5:0]) | (i_arsize != 3'b101) | i_arburst[1]};
  assign o_rvalid = buf_cnt_q != 2'd0;
  assign r_pop = o_rvalid & i_rready;
  // a beat leaving the buffer this cycle frees its slot, which keeps a burst streaming at 1 beat/cycle
  assign issue = (state_q == BURST) && (({1'b0, buf_cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, r_pop}));
  assign o_mem_cs = issue & ~cur_err_q;
  assign o_mem_addr = cur_addr_q;
  assign r_tag = buf_tag_q[buf_rp_q];
  assign o_rdata = buf_data_q[buf_rp_q];
  assign o_rid = r_tag[TW-1:2];
  assign o_rresp = {r_tag[1], 1'b0};
  assign o_rlast = r_tag[0];
  assign o_arready = arready_q;
  assign o_busy = ~empty | state_q | inflight_q | o_rvalid;
  always_comb begin
    q_mem_d = q_mem_q;
    if (push) q_mem_d[wp_q[PW-1:0]] = entry;
    wp_d = wp_q + {{PW{1'b0}}, push};
    rp_d = rp_q + {{PW{1'b0}}, pop};
    arready_d = ~((wp_d[PW] ^ rp_d[PW]) & (wp_d[PW-1:0] == rp_d[PW-1:0]));
    state_d = state_q;
    cur_id_d = cur_id_q;
    cur_addr_d = cur_addr_q;
    cur_fixed_d = cur_fixed_q;
    cur_err_d = cur_err_q;
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      state_d = BURST;
      cur_id_d = head[EW-1 -: AXI_IDW];
      cur_addr_d = head[MEM_AW+5:6];
      beat_cnt_d = {1'b0, head[5:2]} + 5'd1;
      cur_fixed_d = head[1];
      cur_err_d = head[0];
    end
    if (issue) begin
      state_d = beat_cnt_q == 5'd1 ? IDLE : BURST;
      beat_cnt_d = beat_cnt_q - 5'd1;
      cur_addr_d = cur_fixed_q ? cur_addr_q : cur_addr_q + MEM_AW'(1);
    end
    inflight_d = issue;
    pend_tag_d = {cur_id_q, cur_err_q, beat_cnt_q == 5'd1};
    buf_data_d = buf_data_q;
    buf_tag_d = buf_tag_q;
    if (inflight_q) begin
      buf_data_d[buf_wp_q] = pend_tag_q[1] ? '0 : i_mem_rdata;
      buf_tag_d[buf_wp_q] = pend_tag_q;
    end
    buf_wp_d = buf_wp_q ^ inflight_q;
    buf_rp_d = buf_rp_q ^ r_pop;
    buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, r_pop};
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < AR_DEPTH; i++) q_mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      arready_q <= 1'b0;
      state_q <= IDLE;
      cur_id_q <= '0;
      cur_addr_q <= '0;
      cur_fixed_q <= 1'b0;
      cur_err_q <= 1'b0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      pend_tag_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_tag_q[i] <= '0;
      end
      buf_wp_q <= 1'b0;
      buf_rp_q <= 1'b0;
      buf_cnt_q <= '0;
    end else begin
      q_mem_q <= q_mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      arready_q <= arready_d;
      state_q <= state_d;
      cur_id_q <= cur_id_d;
      cur_addr_q <= cur_addr_d;
      cur_fixed_q <= cur_fixed_d;
      cur_err_q <= cur_err_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      pend_tag_q <= pend_tag_d;
      buf_data_q <= buf_data_d;
      buf_tag_q <= buf_tag_d;
      buf_wp_q <= buf_wp_d;
      buf_rp_q <= buf_rp_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end
endmodule

// File: tb/tb_idma_sync_256b_rd_slv.sv
// tb_idma_sync_256b_rd_slv: transaction-level scoreboard bench for the iDMA 256b read responder.
module tb_idma_sync_256b_rd_slv;
  typedef struct packed {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } beat_t;

  logic aclk = 0, aresetn = 0;
  logic i_arvalid = 0, i_rready;
  logic [3:0] i_arid = 0, i_arlen = 0;
  logic [31:0] i_araddr = 0;
  logic [2:0] i_arsize = 0;
  logic [1:0] i_arburst = 0;
  logic o_arready, o_rvalid, o_rlast, o_mem_cs, o_busy;
  logic [3:0] o_rid;
  logic [255:0] o_rdata, mem_rdata;
  logic [1:0] o_rresp;
  logic [9:0] o_mem_addr;

  int tests = 0, fails = 0, cyc = 0, rmode = 0;
  int ar_cyc = 0, first_rv = -1, last_rv = -1;
  beat_t exp_q[$];
  beat_t r_log[$];
  logic [9:0] addr_q[$];
  logic [9:0] cs_log[$];
  beat_t cur_b, held;
  logic hold_v = 0;

  idma_sync_256b_rd_slv dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_arvalid(i_arvalid), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .o_arready(o_arready),
    .o_rvalid(o_rvalid), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .i_rready(i_rready), .o_mem_cs(o_mem_cs), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(mem_rdata), .o_busy(o_busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  function automatic logic [255:0] memf(input logic [9:0] a);
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'hC0DE0000 ^ {18'd0, a, 4'(j)};
    return d;
  endfunction

  always @(posedge aclk) mem_rdata <= o_mem_cs ? memf(o_mem_addr) : {8{$urandom}};

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: expand an accepted AR into the beats and SRAM addresses it must produce
  task automatic model_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    bit err;
    int w;
    beat_t b;
    err = (a[31:15] != 0) || (sz != 3'b101) || bu[1];
    for (int k = 0; k <= int'(len); k++) begin
      w = (bu == 2'b00) ? int'(a[14:5]) : (int'(a[14:5]) + k) % 1024;
      if (!err) addr_q.push_back(10'(w));
      b.id = id;
      b.data = err ? '0 : memf(10'(w));
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (k == int'(len));
      exp_q.push_back(b);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) hold_v = 0;
    else begin
      if (i_arvalid && o_arready) begin
        model_ar(i_arid, i_araddr, i_arlen, i_arsize, i_arburst);
        ar_cyc = cyc;
      end
      if (o_mem_cs) begin
        cs_log.push_back(o_mem_addr);
        chk("mem_cs_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("mem_addr", o_mem_addr, addr_q.pop_front());
      end
      cur_b = {o_rid, o_rdata, o_rresp, o_rlast};
      if (hold_v) chk("r_stable", {o_rvalid, cur_b}, {1'b1, held});
      if (o_rvalid && i_rready) begin
        r_log.push_back(cur_b);
        if (first_rv < 0) first_rv = cyc;
        last_rv = cyc;
        chk("r_beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("r_beat", cur_b, exp_q.pop_front());
      end
      hold_v = o_rvalid && !i_rready;
      held = cur_b;
    end
  end

  initial begin
    i_rready = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0: i_rready = 1;
        1: i_rready = !i_rready;
        2: i_rready = 1'($urandom_range(0, 1));
        default: i_rready = 0;
      endcase
    end
  end

  task automatic wait_ar();
    int n = 0;
    logic hs;
    do begin
      @(negedge aclk);
      hs = o_arready;
      @(posedge aclk);
      #1;
      n++;
    end while (!hs && n < 500);
    i_arvalid = 0;
    chk("ar_accept", hs, 1);
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
    i_arvalid = 1;
    i_arid = id;
    i_araddr = a;
    i_arlen = len;
    i_arsize = sz;
    i_arburst = bu;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz = 3'b101, input logic [1:0] bu = 2'b01);
    set_ar(id, a, len, sz, bu);
    wait_ar();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    chk("drain_in_time", n < 2000, 1);
  endtask

  task automatic clear_logs();
    r_log.delete();
    cs_log.delete();
    first_rv = -1;
    last_rv = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_outputs", {o_arready, o_rvalid, o_rid, o_rdata, o_rresp, o_rlast, o_mem_cs, o_mem_addr, o_busy}, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("arready_before_edge", o_arready, 0);
    @(posedge aclk);
    #1;
    chk("arready_after_reset", o_arready, 1);

    // single INCR burst with fixed latency and back-to-back beats
    rmode = 0;
    clear_logs();
    send_ar(4'd5, 32'h40, 4'd3);
    drain();
    chk("t1_first_rvalid_latency", first_rv - ar_cyc, 4);
    chk("t1_stream", last_rv - first_rv, 3);
    chk("t1_beats", r_log.size(), 4);
    chk("t1_addrs", {cs_log[0], cs_log[1], cs_log[2], cs_log[3]}, {10'd2, 10'd3, 10'd4, 10'd5});
    chk("t1_rid", r_log[0].id, 5);
    chk("t1_last", {r_log[0].last, r_log[1].last, r_log[2].last, r_log[3].last}, 4'b0001);
    chk("t1_okay", r_log[3].resp, 0);

    // full queue holds the next request until the FSM pops
    rmode = 3;
    clear_logs();
    send_ar(4'd1, 32'h100, 4'd7);
    repeat (5) @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) send_ar(4'(2 + i), 32'h200 + 32'(i) * 32'h80, 4'(i));
    set_ar(4'd6, 32'h400, 4'd2, 3'b101, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("t2_full_hold", o_arready, 0);
      @(posedge aclk);
      #1;
    end
    chk("t2_credit_cap", cs_log.size(), 2);
    rmode = 0;
    wait_ar();
    drain();
    chk("t2_beats", r_log.size(), 8 + 1 + 2 + 3 + 4 + 3);
    chk("t2_order", {r_log[0].id, r_log[8].id, r_log[9].id, r_log[11].id, r_log[14].id, r_log[18].id},
        {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});

    // toggling rready
    rmode = 1;
    clear_logs();
    send_ar(4'd7, 32'h0, 4'd15);
    drain();
    chk("t3_beats", r_log.size(), 16);
    chk("t3_word9", r_log[9].data, memf(10'd9));

    // out-of-window, bad size, bad burst
    rmode = 0;
    clear_logs();
    send_ar(4'd8, 32'h0001_0000, 4'd2);
    send_ar(4'd9, 32'h60, 4'd2, 3'b100);
    send_ar(4'd10, 32'h60, 4'd2, 3'b101, 2'b10);
    drain();
    chk("t4_no_cs", cs_log.size(), 0);
    chk("t4_beats", r_log.size(), 9);
    chk("t4_first", r_log[0], {4'd8, 256'd0, 2'b10, 1'b0});
    chk("t4_last", {r_log[2].last, r_log[5].last, r_log[8].last, r_log[8].resp}, {3'b111, 2'b10});

    // FIXED and wrapping INCR
    clear_logs();
    send_ar(4'd11, 32'd7 * 32, 4'd3, 3'b101, 2'b00);
    send_ar(4'd12, 32'd1022 * 32, 4'd3);
    drain();
    chk("t5_fixed", {cs_log[0], cs_log[1], cs_log[2], cs_log[3]}, {4{10'd7}});
    chk("t5_wrap", {cs_log[4], cs_log[5], cs_log[6], cs_log[7]}, {10'd1022, 10'd1023, 10'd0, 10'd1});

    // single beat
    clear_logs();
    send_ar(4'd13, 32'h3E0, 4'd0);
    drain();
    chk("t5_single", {r_log.size(), r_log[0].last}, {32'd1, 1'b1});

    // reset mid-burst
    clear_logs();
    send_ar(4'd14, 32'h800, 4'd7);
    send_ar(4'd15, 32'h900, 4'd3);
    for (int n = 0; n < 200 && r_log.size() < 1; n++) @(negedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 0;
    #1;
    chk("t6_reset_outputs", {o_arready, o_rvalid, o_rid, o_rdata, o_rresp, o_rlast, o_mem_cs, o_mem_addr, o_busy}, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    clear_logs();
    repeat (10) @(posedge aclk);
    #1;
    chk("t6_no_stale_beats", r_log.size(), 0);
    chk("t6_idle", o_busy, 0);
    send_ar(4'd3, 32'h120, 4'd2);
    drain();
    chk("t6_new_burst", r_log.size(), 3);

    // random traffic
    rmode = 2;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int r;
      logic [1:0] bu;
      a = $urandom;
      if ($urandom_range(0, 9) < 8) a[31:15] = '0;
      r = $urandom_range(0, 9);
      bu = r < 4 ? 2'b01 : r < 8 ? 2'b00 : r == 8 ? 2'b10 : 2'b11;
      send_ar(4'($urandom), a, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 9 ? 3'b101 : 3'($urandom), bu);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
    end
    rmode = 0;
    drain();
    chk("rand_all_drained", exp_q.size() + addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
